// File: rtl/io_bus_pkg.sv
// Shared types for the M32632 IO bus controller: region and FSM encodings, CFG address tag.
// Imported by the decoder and the controller top.
package io_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_ROM,
        REG_TUBE,
        REG_CFG,
        REG_UNMAP
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam logic [19:0] CFG_TAG = 20'hF9000;

endpackage

// File: rtl/io_bus_decode.sv
// Combinational IO address decode to a region; no state, zero latency.
// Optional CFG region when IO_BUS_CFG_REG_EN is defined.
module io_bus_decode
    import io_bus_pkg::*;
#(
    parameter int              ADDR_W       = 24,
    parameter int              RAM_TOP_BITS = 3,
    parameter logic [5:0]      ROM_TAG      = 6'b111100,
    parameter logic [ADDR_W-5:0] TUBE_TAG   = 20'hFFFFF
) (
    input  logic [ADDR_W-1:0] io_a,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic              bootmode,
    output region_t           region
);

    logic is_rd;
    logic ram_hit;
    logic rom_hit;
    logic tube_hit;
    logic unused_lo;

    // A simultaneous read and write strobe is treated as a write.
    assign is_rd    = io_rd && !io_wr;
    assign ram_hit  = (io_a[ADDR_W-1 -: RAM_TOP_BITS] == '0);
    assign rom_hit  = (io_a[ADDR_W-1 -: 6] == ROM_TAG);
    assign tube_hit = (io_a[ADDR_W-1:4] == TUBE_TAG);
    assign unused_lo = ^io_a[3:0];

`ifdef IO_BUS_CFG_REG_EN
    logic cfg_hit;
    assign cfg_hit = (io_a[ADDR_W-1:4] == (ADDR_W-4)'(CFG_TAG));
`endif

    always_comb begin
        region = REG_UNMAP;
        if (bootmode) begin
            if (is_rd) region = REG_ROM;
        end else if (ram_hit) begin
            region = REG_RAM;
        end else if (is_rd && rom_hit) begin
            region = REG_ROM;
        end else if (tube_hit) begin
            region = REG_TUBE;
`ifdef IO_BUS_CFG_REG_EN
        end else if (is_rd && cfg_hit) begin
            region = REG_CFG;
`endif
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// IO bus controller: region selects, per-region wait states, registered read data, boot overlay.
// io_ready W+1 cycles after strobe accept; CPU holds strobe until io_ready. CFG region via IO_BUS_CFG_REG_EN.
module io_bus_ctrl
    import io_bus_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter int                DATA_W       = 32,
    parameter int                RAM_TOP_BITS = 3,
    parameter logic [5:0]        ROM_TAG      = 6'b111100,
    parameter logic [ADDR_W-5:0] TUBE_TAG     = 20'hFFFFF,
    parameter int                RAM_WAIT     = 0,
    parameter int                ROM_WAIT     = 1,
    parameter int                TUBE_WAIT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_a,
    output logic [DATA_W-1:0] io_q,
    output logic              io_ready,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [DATA_W-1:0] rom_dout,
    input  logic [7:0]        tube_dout,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              rom_en,
    output logic              tube_cs,
    output logic              bootmode,
    output logic              bus_err,
    input  logic [7:0]        cfg_sw
);

    state_t            state_q, state_d;
    region_t           region_q, dec_region, cur_region;
    logic              wr_q, tag_q, cur_wr;
    logic [3:0]        cnt_q, cnt_d, dec_wait;
    logic              strobe, accept, sel_vld, load;
    logic              bootmode_q;
    logic [DATA_W-1:0] load_dat;

    io_bus_decode #(
        .ADDR_W       (ADDR_W),
        .RAM_TOP_BITS (RAM_TOP_BITS),
        .ROM_TAG      (ROM_TAG),
        .TUBE_TAG     (TUBE_TAG)
    ) u_decode (
        .io_a     (io_a),
        .io_rd    (io_rd),
        .io_wr    (io_wr),
        .bootmode (bootmode_q),
        .region   (dec_region)
    );

    assign strobe = io_rd || io_wr;
    assign accept = (state_q == ST_IDLE) && strobe && !rst;

    always_comb begin
        case (dec_region)
            REG_RAM:  dec_wait = 4'(RAM_WAIT);
            REG_ROM:  dec_wait = 4'(ROM_WAIT);
            REG_TUBE: dec_wait = 4'(TUBE_WAIT);
            default:  dec_wait = 4'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    if (dec_wait == 4'd0) begin
                        state_d = ST_ACK;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = dec_wait - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In the accepting IDLE cycle the live decode drives the selects; afterwards the latched copy does.
    assign cur_region = (state_q == ST_IDLE) ? dec_region : region_q;
    assign cur_wr     = (state_q == ST_IDLE) ? io_wr : wr_q;
    assign sel_vld    = accept || (state_q != ST_IDLE);

    assign ram_en  = sel_vld && (cur_region == REG_RAM);
    assign ram_oe  = sel_vld && (cur_region == REG_RAM) && !cur_wr;
    assign ram_we  = sel_vld && (cur_region == REG_RAM) && cur_wr;
    assign rom_en  = sel_vld && (cur_region == REG_ROM);
    assign tube_cs = sel_vld && (cur_region == REG_TUBE);

    assign io_ready = (state_q == ST_ACK);
    assign bus_err  = (state_q == ST_ACK) && (region_q == REG_UNMAP);
    assign bootmode = bootmode_q;

    always_comb begin
        load_dat = '0;
        if (!cur_wr) begin
            case (cur_region)
                REG_RAM:  load_dat = ram_dout;
                REG_ROM:  load_dat = rom_dout;
                REG_TUBE: load_dat = {{(DATA_W-8){1'b0}}, tube_dout};
`ifdef IO_BUS_CFG_REG_EN
                REG_CFG:  load_dat = {{(DATA_W-8){1'b0}}, cfg_sw};
`endif
                default:  load_dat = '0;
            endcase
        end
    end

`ifndef IO_BUS_CFG_REG_EN
    logic unused_cfg;
    assign unused_cfg = ^cfg_sw;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            region_q   <= REG_UNMAP;
            wr_q       <= 1'b0;
            tag_q      <= 1'b0;
            io_q       <= '0;
            bootmode_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && strobe) begin
                region_q <= dec_region;
                wr_q     <= io_wr;
                tag_q    <= (io_a[ADDR_W-1 -: 6] == ROM_TAG);
            end
            if (load) io_q <= load_dat;
            // Overlay drops once software has read from the real ROM window.
            if (state_q == ST_ACK && !wr_q && tag_q) bootmode_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: u0 uses default waits, u1 uses RAM_WAIT = 3.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_io_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_rd, io_wr, io_rd1, io_wr1;
    logic [23:0] io_a, io_a1;
    logic [31:0] ram_dout, rom_dout;
    logic [7:0]  tube_dout, cfg_sw;

    logic [31:0] io_q, io_q1;
    logic io_ready, ram_en, ram_oe, ram_we, rom_en, tube_cs, bootmode, bus_err;
    logic io_ready1, ram_en1, ram_oe1, ram_we1, rom_en1, tube_cs1, bootmode1, bus_err1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_bus_ctrl u0 (
        .clk(clk), .rst(rst), .io_rd(io_rd), .io_wr(io_wr), .io_a(io_a), .io_q(io_q),
        .io_ready(io_ready), .ram_dout(ram_dout), .rom_dout(rom_dout), .tube_dout(tube_dout),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we), .rom_en(rom_en), .tube_cs(tube_cs),
        .bootmode(bootmode), .bus_err(bus_err), .cfg_sw(cfg_sw)
    );

    io_bus_ctrl #(.RAM_WAIT(3)) u1 (
        .clk(clk), .rst(rst), .io_rd(io_rd1), .io_wr(io_wr1), .io_a(io_a1), .io_q(io_q1),
        .io_ready(io_ready1), .ram_dout(ram_dout), .rom_dout(rom_dout), .tube_dout(tube_dout),
        .ram_en(ram_en1), .ram_oe(ram_oe1), .ram_we(ram_we1), .rom_en(rom_en1), .tube_cs(tube_cs1),
        .bootmode(bootmode1), .bus_err(bus_err1), .cfg_sw(cfg_sw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until io_ready is seen on the chosen instance; -1 when the bound expires.
    task automatic wait_ready(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if ((which == 0 && io_ready) || (which == 1 && io_ready1)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({io_ready, bus_err, ram_en, ram_oe, ram_we, rom_en, tube_cs} !== 7'b0) begin
            n_bad++; $display("FAIL reset_outputs got=%b want=0000000",
                {io_ready, bus_err, ram_en, ram_oe, ram_we, rom_en, tube_cs});
        end
        n_cmp++;
        if (bootmode !== 1'b1 || io_q !== 32'h0) begin
            n_bad++; $display("FAIL reset_state bootmode=%b io_q=%h want 1/00000000", bootmode, io_q);
        end
    endtask

    task automatic test_boot();
        int n;
        rom_dout = 32'h1234_5678;
        ram_dout = 32'hCAFE_0001;
        io_a = 24'h000100; io_rd = 1'b1; #1;
        n_cmp++;
        if (rom_en !== 1'b1 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL boot_rom_sel rom_en=%b ram_en=%b want 1/0", rom_en, ram_en);
        end
        wait_ready(0, n);
        n_cmp++;
        if (n !== 2) begin n_bad++; $display("FAIL boot_rom_latency got=%0d want=2", n); end
        n_cmp++;
        if (io_q !== 32'h1234_5678) begin n_bad++; $display("FAIL boot_rom_data got=%h want=12345678", io_q); end
        io_rd = 1'b0; step();
        n_cmp++;
        if (bootmode !== 1'b1) begin n_bad++; $display("FAIL boot_stays got=%b want=1", bootmode); end

        io_a = 24'hF00000; io_rd = 1'b1;
        wait_ready(0, n);
        io_rd = 1'b0; step();
        n_cmp++;
        if (bootmode !== 1'b0) begin n_bad++; $display("FAIL boot_clear got=%b want=0", bootmode); end

        io_a = 24'h000100; io_rd = 1'b1; #1;
        n_cmp++;
        if ({ram_en, ram_oe, ram_we, rom_en} !== 4'b1100) begin
            n_bad++; $display("FAIL ram_read_sel got=%b want=1100", {ram_en, ram_oe, ram_we, rom_en});
        end
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1 || io_q !== 32'hCAFE_0001) begin
            n_bad++; $display("FAIL ram_read latency=%0d io_q=%h want 1/cafe0001", n, io_q);
        end
        io_rd = 1'b0; step();
    endtask

    task automatic test_wait_states();
        int n;
        io_a1 = 24'hF00000; io_rd1 = 1'b1;
        wait_ready(1, n);
        io_rd1 = 1'b0; step();
        io_a1 = 24'h001000; io_wr1 = 1'b1; #1;
        n = -1;
        // Selects must hold from the accepting cycle through ACK.
        for (int i = 0; i <= 20; i++) begin
            n_cmp++;
            if (ram_we1 !== 1'b1 || ram_oe1 !== 1'b0) begin
                n_bad++; $display("FAIL wait_we cycle=%0d ram_we=%b ram_oe=%b want 1/0", i, ram_we1, ram_oe1);
            end
            if (io_ready1) begin n = i; break; end
            step();
        end
        n_cmp++;
        if (n !== 4 || bus_err1 !== 1'b0) begin
            n_bad++; $display("FAIL wait_latency got=%0d bus_err=%b want 4/0", n, bus_err1);
        end
        io_wr1 = 1'b0; step();
        n_cmp++;
        if (io_ready1 !== 1'b0 || ram_we1 !== 1'b0) begin
            n_bad++; $display("FAIL wait_pulse io_ready=%b ram_we=%b want 0/0", io_ready1, ram_we1);
        end
    endtask

    task automatic test_tube();
        int n;
        tube_dout = 8'hA5;
        io_a = 24'hFFFFF6; io_rd = 1'b1; #1;
        n_cmp++;
        if (tube_cs !== 1'b1 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL tube_sel tube_cs=%b ram_en=%b want 1/0", tube_cs, ram_en);
        end
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1 || io_q !== 32'h0000_00A5) begin
            n_bad++; $display("FAIL tube_read latency=%0d io_q=%h want 1/000000a5", n, io_q);
        end
        io_rd = 1'b0; step();
    endtask

    task automatic test_unmapped();
        int n;
        io_a = 24'hF00010; io_wr = 1'b1; #1;
        n_cmp++;
        if ({ram_en, ram_oe, ram_we, rom_en, tube_cs} !== 5'b0) begin
            n_bad++; $display("FAIL unmap_sel got=%b want=00000", {ram_en, ram_oe, ram_we, rom_en, tube_cs});
        end
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1 || bus_err !== 1'b1 || io_q !== 32'h0) begin
            n_bad++; $display("FAIL unmap_ack latency=%0d bus_err=%b io_q=%h want 1/1/0", n, bus_err, io_q);
        end
        io_wr = 1'b0; step();
        n_cmp++;
        if (bus_err !== 1'b0) begin n_bad++; $display("FAIL unmap_err_pulse got=%b want=0", bus_err); end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        ram_dout = 32'h1111_1111;
        io_a = 24'h000200; io_rd = 1'b1;
        wait_ready(0, n);
        n_cmp++;
        if (n !== 1 || io_q !== 32'h1111_1111) begin
            n_bad++; $display("FAIL b2b_first latency=%0d io_q=%h want 1/11111111", n, io_q);
        end
        ram_dout = 32'h2222_2222;
        wait_ready(0, gap);
        n_cmp++;
        if (gap !== 2 || io_q !== 32'h2222_2222) begin
            n_bad++; $display("FAIL b2b_second gap=%0d io_q=%h want 2/22222222", gap, io_q);
        end
        io_rd = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        io_a = 24'hF00004; io_rd = 1'b1;
        step();
        rst = 1'b1; #1;
        n_cmp++;
        if ({io_ready, bus_err, ram_en, ram_oe, ram_we, rom_en, tube_cs} !== 7'b0 || io_q !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid_out got=%b io_q=%h want 0000000/0",
                {io_ready, bus_err, ram_en, ram_oe, ram_we, rom_en, tube_cs}, io_q);
        end
        n_cmp++;
        if (bootmode !== 1'b1) begin n_bad++; $display("FAIL rst_mid_boot got=%b want=1", bootmode); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (io_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready cycle=%0d got=1 want=0", i); end
        end
        io_rd = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_config();
        int n;
        io_a = 24'hF00000; io_rd = 1'b1;
        wait_ready(0, n);
        io_rd = 1'b0; step();
        cfg_sw = 8'h03;
        io_a = 24'hF90000; io_rd = 1'b1;
        wait_ready(0, n);
`ifdef IO_BUS_CFG_REG_EN
        n_cmp++;
        if (n !== 1 || io_q !== 32'h3 || bus_err !== 1'b0) begin
            n_bad++; $display("FAIL cfg_read latency=%0d io_q=%h bus_err=%b want 1/00000003/0", n, io_q, bus_err);
        end
`else
        n_cmp++;
        if (n !== 1 || io_q !== 32'h0 || bus_err !== 1'b1) begin
            n_bad++; $display("FAIL cfg_unmapped latency=%0d io_q=%h bus_err=%b want 1/00000000/1", n, io_q, bus_err);
        end
`endif
        io_rd = 1'b0; step();
    endtask

    initial begin
        rst = 1'b1;
        io_rd = 1'b0; io_wr = 1'b0; io_a = '0;
        io_rd1 = 1'b0; io_wr1 = 1'b0; io_a1 = '0;
        ram_dout = '0; rom_dout = '0; tube_dout = '0; cfg_sw = '0;
        step(); step();
        test_reset();
        rst = 1'b0;
        step();
        test_boot();
        test_wait_states();
        test_tube();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
